// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the restoring divider
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic DIV0_Q_BIT = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE, FIXUP} state_t;
endpackage

// File: rtl/cla_subtractor.sv
// cla_subtractor: a + ~b + 1 on a 4-bit-group carry-lookahead adder, split into low bits and MSB
module cla_subtractor #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-2:0] diff,
  output logic             borrow
);
  localparam int NB = (WIDTH + 3) / 4;
  logic [WIDTH-1:0] nb, p, c;
  logic [WIDTH-2:0] g;
  logic [NB-1:0] bc;
  assign nb = ~b;
  assign p = a ^ nb;
  assign g = a[WIDTH-2:0] & nb[WIDTH-2:0];
  assign bc[0] = 1'b1;
  for (genvar k = 0; k < NB - 1; k++) begin : g_blk
    assign bc[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                   | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | ((&p[4*k+3 -: 4]) & bc[k]);
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i % 4 == 0) begin : g_c0
      assign c[i] = bc[i/4];
    end else if (i % 4 == 1) begin : g_c1
      assign c[i] = g[i-1] | (p[i-1] & bc[i/4]);
    end else if (i % 4 == 2) begin : g_c2
      assign c[i] = g[i-1] | (p[i-1] & g[i-2]) | (p[i-1] & p[i-2] & bc[i/4]);
    end else begin : g_c3
      assign c[i] = g[i-1] | (p[i-1] & g[i-2]) | (p[i-1] & p[i-2] & g[i-3])
                  | (p[i-1] & p[i-2] & p[i-3] & bc[i/4]);
    end
  end
  assign {borrow, diff} = p ^ c;
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: one-bit-per-cycle restoring divider; DIV_SIGNED_EN selects two's complement mode
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t state;
  logic [WIDTH-1:0] r, q, dv, t_low, r_nx, q_nx, dd_mag, dv_mag;
  logic [CNT_W-1:0] cnt;
  logic t_borrow;
  cla_subtractor #(.WIDTH(WIDTH + 1)) u_trial (
    .a({r, q[WIDTH-1]}),
    .b({1'b0, dv}),
    .diff(t_low),
    .borrow(t_borrow)
  );
  assign r_nx = t_borrow ? {r[WIDTH-2:0], q[WIDTH-1]} : t_low;
  assign q_nx = {q[WIDTH-2:0], ~t_borrow};
`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;
  logic [WIDTH-1:0] neg_a, neg_b;
  cla_subtractor #(.WIDTH(WIDTH)) u_neg_a (
    .a('0),
    .b(state == FIXUP ? q : dividend),
    .diff(neg_a[WIDTH-2:0]),
    .borrow(neg_a[WIDTH-1])
  );
  cla_subtractor #(.WIDTH(WIDTH)) u_neg_b (
    .a('0),
    .b(state == FIXUP ? r : divisor),
    .diff(neg_b[WIDTH-2:0]),
    .borrow(neg_b[WIDTH-1])
  );
  assign dd_mag = dividend[WIDTH-1] ? neg_a : dividend;
  assign dv_mag = divisor[WIDTH-1] ? neg_b : divisor;
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      cnt <= '0;
      r <= '0;
      q <= '0;
      dv <= '0;
`ifdef DIV_SIGNED_EN
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          done <= 1'b0;
          div_by_zero <= 1'b0;
          cnt <= '0;
          r <= '0;
          q <= dd_mag;
          dv <= dv_mag;
`ifdef DIV_SIGNED_EN
          q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg <= dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            state <= DONE;
            done <= 1'b1;
            div_by_zero <= 1'b1;
            quotient <= {WIDTH{DIV0_Q_BIT}};
            remainder <= dividend;
          end else begin
            state <= RUN;
            busy <= 1'b1;
          end
        end
        RUN: begin
          q <= q_nx;
          r <= r_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            busy <= 1'b0;
`ifdef DIV_SIGNED_EN
            state <= FIXUP;
`else
            state <= DONE;
            done <= 1'b1;
            quotient <= q_nx;
            remainder <= r_nx;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        FIXUP: begin
          state <= DONE;
          done <= 1'b1;
          quotient <= q_neg ? neg_a : q;
          remainder <= r_neg ? neg_b : r;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: randomized and directed checks against an arithmetic reference model
module tb_seq_restoring_divider;
  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end
`ifdef DIV_SIGNED_EN
    else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      q = a;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
`else
    else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction
  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    check({tag, "_q"}, 64'(quotient), 64'd0);
    check({tag, "_r"}, 64'(remainder), 64'd0);
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int ign_at, input int rst_at);
    logic [W-1:0] eq, er;
    logic ez;
    int k, busy_n;
    model(a, b, eq, er, ez);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    k = 1;
    busy_n = int'(busy);
    if (!ez) check("done_drop", 64'(done), 64'd0);
    while (!done && k < LAT + 8) begin
      if (k == ign_at) begin
        start = 1'b1;
        dividend = 9;
        divisor = 9;
      end
      if (k == rst_at) rst = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
      if (rst) begin
        rst = 1'b0;
        check_idle_zero("abort");
        return;
      end
      busy_n += int'(busy);
    end
    check("done_edge", 64'(k), ez ? 64'd1 : 64'(LAT));
    check("busy_cycles", 64'(busy_n), ez ? 64'd0 : 64'(W));
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(ez));
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", 64'(done), 64'd1);
    check("hold_q", 64'(quotient), 64'(eq));
    check("hold_r", 64'(remainder), 64'(er));
  endtask
  initial begin
    #5ms;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end
  initial begin
    logic [W-1:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
    run_op(32'd100, 32'd7, 0, 0);
    run_op(32'd5, 32'd0, 0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 0, 0);
    run_op(32'd3, 32'd10, 0, 0);
    run_op(32'd1000, 32'd3, 10, 0);
    run_op(32'd1000, 32'd3, 0, 16);
    run_op(32'd50, 32'd5, 0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 0, 0);
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 15);
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = a >> $urandom_range(0, 4);
        default: b = $urandom;
      endcase
      run_op(a, b, (i % 5 == 0) ? $urandom_range(1, 20) : 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
